// File: rtl/imem_access_arbiter_if.sv
// Bundle of the fetch, loader and memory-port signals around the instruction memory arbiter.
interface imem_access_arbiter_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
);
   logic          f_req;
   logic [AW-1:0] f_addr;
   logic          f_gnt;
   logic          f_rvalid;
   logic [DW-1:0] f_rdata;

   logic          l_req;
   logic          l_we;
   logic [AW-1:0] l_addr;
   logic [DW-1:0] l_wdata;
   logic          l_gnt;
   logic          l_rvalid;
   logic [DW-1:0] l_rdata;
   logic          l_err;

   logic          m_en;
   logic          m_we;
   logic [AW-3:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rdata;

   logic          busy;

   // Arbiter view.
   modport slave (
      input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, m_rdata,
      output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, l_err,
             m_en, m_we, m_addr, m_wdata, busy
   );

   // Requester/memory view.
   modport master (
      output f_req, f_addr, l_req, l_we, l_addr, l_wdata, m_rdata,
      input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, l_err,
             m_en, m_we, m_addr, m_wdata, busy
   );
endinterface

// File: rtl/imem_access_arbiter.sv
// Shares the instruction memory port between fetch (read-only) and the loader (read/write),
// one access per cycle, and routes read data back to its owner after MEM_LAT cycles.
module imem_access_arbiter #(
   parameter int unsigned AW         = 32,
   parameter int unsigned DW         = 32,
   parameter int unsigned MEM_LAT    = 1,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   imem_access_arbiter_if.slave  bus
);

   localparam int unsigned IW = AW - 2;
   localparam int unsigned CW = 4;
   localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

   typedef struct packed {
      logic          we;
      logic [IW-1:0] idx;
      logic [DW-1:0] wdata;
   } mem_req_t;

   logic [CW-1:0]      starve_q, starve_d;
   logic [MEM_LAT-1:0] vld_q, vld_d;
   logic [MEM_LAT-1:0] own_q, own_d;   // 1 = loader owns the read

   logic     fetch_win_c;
   logic     f_gnt_c;
   logic     l_gnt_c;
   logic     issue_rd_c;
   logic     resp_vld_c;
   logic     resp_own_c;
   mem_req_t req_c;

   logic unused_fetch_lsbs;
   assign unused_fetch_lsbs = ^bus.f_addr[1:0];

   // Loader wins unless fetch has waited STARVE_MAX loader grants; nothing granted in reset.
   always_comb begin
      fetch_win_c = bus.f_req && (!bus.l_req || (starve_q == STARVE_LIM));
      f_gnt_c     = rst && fetch_win_c;
      l_gnt_c     = rst && bus.l_req && !fetch_win_c;
      issue_rd_c  = f_gnt_c || (l_gnt_c && !bus.l_we);
   end

   // Select the granted access for the memory port.
   always_comb begin
      req_c = '0;
      if (f_gnt_c) begin
         req_c.idx = bus.f_addr[AW-1:2];
      end else if (l_gnt_c) begin
         req_c.we    = bus.l_we;
         req_c.idx   = bus.l_addr[AW-1:2];
         req_c.wdata = bus.l_wdata;
      end
   end

   always_comb begin
      starve_d = starve_q;
      if (!bus.f_req || f_gnt_c) begin
         starve_d = '0;
      end else if (l_gnt_c && (starve_q < STARVE_LIM)) begin
         starve_d = starve_q + CW'(1);
      end
   end

   // Response pipeline: one {valid, owner} slot per memory latency cycle.
   if (MEM_LAT > 1) begin : g_shift
      always_comb begin
         vld_d = {vld_q[MEM_LAT-2:0], issue_rd_c};
         own_d = {own_q[MEM_LAT-2:0], l_gnt_c};
      end
   end else begin : g_single
      always_comb begin
         vld_d = issue_rd_c;
         own_d = l_gnt_c;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_q <= '0;
         vld_q    <= '0;
         own_q    <= '0;
      end else begin
         starve_q <= starve_d;
         vld_q    <= vld_d;
         own_q    <= own_d;
      end
   end

   always_comb begin
      resp_vld_c   = vld_q[MEM_LAT-1];
      resp_own_c   = own_q[MEM_LAT-1];

      bus.f_gnt    = f_gnt_c;
      bus.l_gnt    = l_gnt_c;
      bus.l_err    = l_gnt_c && (bus.l_addr[1:0] != 2'b00);

      bus.m_en     = f_gnt_c || l_gnt_c;
      bus.m_we     = req_c.we;
      bus.m_addr   = req_c.idx;
      bus.m_wdata  = req_c.wdata;

      bus.f_rvalid = resp_vld_c && !resp_own_c;
      bus.l_rvalid = resp_vld_c && resp_own_c;
      bus.f_rdata  = (resp_vld_c && !resp_own_c) ? bus.m_rdata : '0;
      bus.l_rdata  = (resp_vld_c && resp_own_c) ? bus.m_rdata : '0;

      bus.busy     = |vld_q;
   end

`ifndef SYNTHESIS
   a_one_gnt: assert property (@(posedge clk) disable iff (!rst)
      !(f_gnt_c && l_gnt_c));
   a_gnt_req: assert property (@(posedge clk) disable iff (!rst)
      (!f_gnt_c || bus.f_req) && (!l_gnt_c || bus.l_req));
   a_starve_bound: assert property (@(posedge clk) disable iff (!rst)
      starve_q <= STARVE_LIM);
`endif

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Bench for imem_access_arbiter: two instances (MEM_LAT=1 and 3) share directed stimulus;
// a cycle-level model with a due-cycle response table checks both every cycle.
module tb_imem_access_arbiter;

   localparam int unsigned AW   = 32;
   localparam int unsigned DW   = 32;
   localparam int          SMAX = 4;

   typedef struct packed {
      logic        f_gnt;
      logic        l_gnt;
      logic        f_rvalid;
      logic        l_rvalid;
      logic        l_err;
      logic        m_en;
      logic        m_we;
      logic        busy;
      logic [29:0] m_addr;
      logic [31:0] m_wdata;
      logic [31:0] f_rdata;
      logic [31:0] l_rdata;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        f_req;
   logic [31:0] f_addr;
   logic        l_req;
   logic        l_we;
   logic [31:0] l_addr;
   logic [31:0] l_wdata;

   logic        load_en;
   logic [5:0]  load_idx;
   logic [31:0] load_dat;
   logic [31:0] mem1 [64];
   logic [31:0] mem3 [64];
   logic [31:0] rd1;
   logic [31:0] rd3 [3];

   int errs   = 0;
   int checks = 0;
   int cyc    = 0;

   bit          ev   [2][64];
   bit          eown [2][64];
   logic [31:0] edat [2][64];
   int          cnt  [2];

   obs_t obs [2];

   always #5 clk = ~clk;

   imem_access_arbiter_if #(.AW(AW), .DW(DW)) if1 ();
   imem_access_arbiter_if #(.AW(AW), .DW(DW)) if3 ();

   imem_access_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1), .STARVE_MAX(SMAX)) u_dut1 (
      .clk(clk), .rst(rst), .bus(if1)
   );
   imem_access_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(3), .STARVE_MAX(SMAX)) u_dut3 (
      .clk(clk), .rst(rst), .bus(if3)
   );

   assign if1.f_req = f_req;   assign if3.f_req = f_req;
   assign if1.f_addr = f_addr; assign if3.f_addr = f_addr;
   assign if1.l_req = l_req;   assign if3.l_req = l_req;
   assign if1.l_we = l_we;     assign if3.l_we = l_we;
   assign if1.l_addr = l_addr; assign if3.l_addr = l_addr;
   assign if1.l_wdata = l_wdata; assign if3.l_wdata = l_wdata;
   assign if1.m_rdata = rd1;
   assign if3.m_rdata = rd3[2];

   assign obs[0] = {if1.f_gnt, if1.l_gnt, if1.f_rvalid, if1.l_rvalid, if1.l_err, if1.m_en,
                    if1.m_we, if1.busy, if1.m_addr, if1.m_wdata, if1.f_rdata, if1.l_rdata};
   assign obs[1] = {if3.f_gnt, if3.l_gnt, if3.f_rvalid, if3.l_rvalid, if3.l_err, if3.m_en,
                    if3.m_we, if3.busy, if3.m_addr, if3.m_wdata, if3.f_rdata, if3.l_rdata};

   // Synchronous-read memories with 1- and 3-cycle read latency.
   always @(posedge clk) begin
      if (load_en) begin
         mem1[load_idx] <= load_dat;
         mem3[load_idx] <= load_dat;
      end else begin
         if (if1.m_en && if1.m_we) mem1[if1.m_addr[5:0]] <= if1.m_wdata;
         if (if3.m_en && if3.m_we) mem3[if3.m_addr[5:0]] <= if3.m_wdata;
      end
      rd1    <= (if1.m_en && !if1.m_we) ? mem1[if1.m_addr[5:0]] : 32'hDEAD_BEEF;
      rd3[0] <= (if3.m_en && !if3.m_we) ? mem3[if3.m_addr[5:0]] : 32'hDEAD_BEEF;
      rd3[1] <= rd3[0];
      rd3[2] <= rd3[1];
   end

   function automatic logic [31:0] init_word(input int i);
      case (i)
         0:       return 32'hFFC4_A303;
         1:       return 32'h0083_2383;
         2:       return 32'h0062_E233;
         default: return 32'h1000_0000 + 32'(i) * 32'h0001_0101;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: priority rule, starvation count, and a table of reads keyed by the cycle they return.
   task automatic model_step(input int k, input obs_t o);
      int    lat;
      int    s;
      int    ns;
      bit    fw;
      bit    lw;
      bit    ef;
      bit    el;
      bit    bsy;
      string p;
      logic [5:0] idx;
      lat = (k == 0) ? 1 : 3;
      p   = (k == 0) ? "lat1" : "lat3";
      s   = cyc % 64;
      if (!rst) begin
         chk({p, " reset ctl"}, 32'({o.f_gnt, o.l_gnt, o.f_rvalid, o.l_rvalid, o.l_err,
                                     o.m_en, o.m_we, o.busy}), 32'h0);
         chk({p, " reset m_addr"}, 32'(o.m_addr), 32'h0);
         chk({p, " reset m_wdata"}, o.m_wdata, 32'h0);
         chk({p, " reset f_rdata"}, o.f_rdata, 32'h0);
         chk({p, " reset l_rdata"}, o.l_rdata, 32'h0);
         for (int j = 0; j < 64; j++) ev[k][j] = 1'b0;
         cnt[k] = 0;
         return;
      end
      fw  = f_req && (!l_req || cnt[k] == SMAX);
      lw  = l_req && !fw;
      ef  = ev[k][s] && !eown[k][s];
      el  = ev[k][s] && eown[k][s];
      bsy = 1'b0;
      for (int j = 0; j < lat; j++) bsy |= ev[k][(cyc + j) % 64];
      chk({p, " f_gnt"}, 32'(o.f_gnt), 32'(fw));
      chk({p, " l_gnt"}, 32'(o.l_gnt), 32'(lw));
      chk({p, " m_en"}, 32'(o.m_en), 32'(fw | lw));
      chk({p, " m_we"}, 32'(o.m_we), 32'(lw & l_we));
      chk({p, " l_err"}, 32'(o.l_err), 32'(lw && (l_addr[1:0] != 2'b00)));
      chk({p, " f_rvalid"}, 32'(o.f_rvalid), 32'(ef));
      chk({p, " l_rvalid"}, 32'(o.l_rvalid), 32'(el));
      chk({p, " f_rdata"}, o.f_rdata, ef ? edat[k][s] : 32'h0);
      chk({p, " l_rdata"}, o.l_rdata, el ? edat[k][s] : 32'h0);
      chk({p, " busy"}, 32'(o.busy), 32'(bsy));
      if (fw) chk({p, " m_addr fetch"}, 32'(o.m_addr), 32'(f_addr[31:2]));
      if (lw) chk({p, " m_addr load"}, 32'(o.m_addr), 32'(l_addr[31:2]));
      if (lw && l_we) chk({p, " m_wdata"}, o.m_wdata, l_wdata);
      ev[k][s] = 1'b0;
      if (fw || (lw && !l_we)) begin
         idx         = fw ? f_addr[7:2] : l_addr[7:2];
         ns          = (cyc + lat) % 64;
         ev[k][ns]   = 1'b1;
         eown[k][ns] = lw;
         edat[k][ns] = (k == 0) ? mem1[idx] : mem3[idx];
      end
      if (!f_req || fw)             cnt[k] = 0;
      else if (lw && cnt[k] < SMAX) cnt[k] = cnt[k] + 1;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         model_step(0, obs[0]);
         model_step(1, obs[1]);
         cyc++;
      end
   end

   task automatic drive(input logic r, input logic fr, input logic [31:0] fa, input logic lr,
                        input logic lwe, input logic [31:0] la, input logic [31:0] lwd);
      @(posedge clk);
      #1;
      rst = r; f_req = fr; f_addr = fa; l_req = lr; l_we = lwe; l_addr = la; l_wdata = lwd;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   initial begin
      logic [9:0] pat1;
      logic [9:0] pat3;
      int         nrv;
      rst = 1'b0; f_req = 1'b1; f_addr = 32'h0;
      l_req = 1'b0; l_we = 1'b0; l_addr = 32'h0; l_wdata = 32'h0;
      load_en = 1'b0; load_idx = '0; load_dat = '0;

      // Preload memories while held in reset with fetch requesting.
      for (int i = 0; i < 64; i++) begin
         @(posedge clk);
         #1;
         load_en = 1'b1; load_idx = 6'(i); load_dat = init_word(i);
      end
      @(posedge clk);
      #1;
      load_en = 1'b0;
      @(negedge clk);
      chk("t1 reset f_gnt", 32'(if1.f_gnt), 32'h0);
      chk("t1 reset m_en", 32'(if3.m_en), 32'h0);

      // Reset release: fetch granted in the same cycle.
      drive(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("t1 f_gnt", 32'(if1.f_gnt), 32'h1);
      chk("t1 m_en", 32'(if3.m_en), 32'h1);
      idle(1);
      chk("t1 lat1 f_rvalid", 32'(if1.f_rvalid), 32'h1);
      chk("t1 lat1 f_rdata", if1.f_rdata, 32'hFFC4_A303);
      idle(2);
      chk("t1 lat3 f_rvalid", 32'(if3.f_rvalid), 32'h1);
      chk("t1 lat3 f_rdata", if3.f_rdata, 32'hFFC4_A303);
      idle(2);

      // Fetch stream 0x0, 0x4, 0x8.
      drive(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("t2 data0", if1.f_rdata, 32'hFFC4_A303);
      drive(1'b1, 1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("t2 data1", if1.f_rdata, 32'h0083_2383);
      idle(1);
      chk("t2 data2", if1.f_rdata, 32'h0062_E233);
      idle(1);
      chk("t2 stream end", 32'(if1.f_rvalid), 32'h0);
      idle(3);

      // Contention: both requesting for 10 cycles.
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'b1, 32'h20, 1'b1, 1'b0, 32'h24, 32'h0);
         pat1[i] = if1.f_gnt;
         pat3[i] = if3.f_gnt;
      end
      chk("t3 grant pattern lat1", 32'(pat1), 32'h210);
      chk("t3 grant pattern lat3", 32'(pat3), 32'h210);
      idle(4);

      // Loader write then read-back.
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 32'h0064_A423);
      chk("t4 write m_we", 32'(if1.m_we), 32'h1);
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
      chk("t4 read m_we", 32'(if1.m_we), 32'h0);
      idle(1);
      chk("t4 l_rvalid", 32'(if1.l_rvalid), 32'h1);
      chk("t4 l_rdata", if1.l_rdata, 32'h0064_A423);
      idle(3);

      // Misaligned loader write.
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h13, 32'h1234_5678);
      chk("t5 l_err", 32'(if1.l_err), 32'h1);
      chk("t5 m_addr", 32'(if1.m_addr), 32'h4);
      chk("t5 m_we", 32'(if1.m_we), 32'h1);
      idle(1);
      chk("t5 l_err pulse", 32'(if1.l_err), 32'h0);
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
      idle(1);
      chk("t5 readback", if1.l_rdata, 32'h1234_5678);
      idle(3);

      // Reset with reads in flight.
      drive(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("t6 busy before", 32'(if3.busy), 32'h1);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("t6 busy in reset", 32'(if3.busy), 32'h0);
      nrv = 0;
      for (int i = 0; i < 6; i++) begin
         idle(1);
         nrv += int'(if1.f_rvalid) + int'(if3.f_rvalid);
      end
      chk("t6 rvalid after reset", 32'(nrv), 32'h0);

      // Mixed traffic, checked by the model only.
      for (int i = 0; i < 40; i++) begin
         drive(1'b1, (i % 3) != 0, 32'((i * 4) & 252), (i % 4) != 3, (i % 5) == 0,
               32'((i * 12 + i % 4) & 255), 32'hC0DE_0000 + 32'(i));
      end
      idle(5);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/imem_access_arbiter.md
Name: imem_access_arbiter

Overview:
Shares the single port of the instruction memory between two requesters: the core fetch stage (read-only) and the program loader (read/write, used for boot image load and debug readback). Arbitrates one access per cycle, issues it on the memory port, and routes the read data back to the owner after a fixed memory latency. Sits between the fetch stage/loader and the instruction memory array.

Parameters:
AW, 32, byte address width; the memory word index is addr[AW-1:2]
DW, 32, data width
MEM_LAT, 1, cycles from m_en to m_rdata valid (1..4)
STARVE_MAX, 4, max consecutive loader grants while fetch is waiting (1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
f_req  in  1  fetch read request
f_addr  in  AW  fetch byte address
f_gnt  out  1  fetch request accepted this cycle
f_rvalid  out  1  fetch read data valid
f_rdata  out  DW  fetch read data
l_req  in  1  loader request
l_we  in  1  loader write enable (1=write, 0=read)
l_addr  in  AW  loader byte address
l_wdata  in  DW  loader write data
l_gnt  out  1  loader request accepted this cycle
l_rvalid  out  1  loader read data valid (reads only)
l_rdata  out  DW  loader read data
l_err  out  1  one-cycle pulse: granted loader access had addr[1:0]!=0
m_en  out  1  memory access strobe
m_we  out  1  memory write enable
m_addr  out  AW-2  memory word index
m_wdata  out  DW  memory write data
m_rdata  in  DW  memory read data, valid MEM_LAT cycles after m_en
busy  out  1  any read in flight

Behaviour:
- Reset (rst=0, async): all outputs 0, starvation counter 0, in-flight pipeline cleared; responses of accesses issued before reset are never delivered.
- Grant is combinational from the requests and the registered state. At most one of f_gnt/l_gnt is high per cycle; a requester is granted only when its req is high.
- Priority: the loader wins by default. Exception: the fetch stage wins if f_req=1 and starve_cnt==STARVE_MAX.
- starve_cnt increments on each cycle with l_gnt=1 while f_req=1, saturating at STARVE_MAX. It clears on f_gnt or when f_req=0.
- Granted access drives the memory port in the same cycle: m_en=1, m_addr=addr[AW-1:2], m_we=l_we for the loader (0 for fetch), m_wdata=l_wdata. When nothing is granted, m_en=0 and m_we=0.
- Misaligned loader access (l_addr[1:0]!=0): still granted and issued with truncated index; l_err pulses in the grant cycle. Fetch addresses are truncated silently.
- Response routing: a MEM_LAT-deep shift register holds {valid, owner} per issued read. Writes do not enter it.
- At stage MEM_LAT, the owner's rvalid=1 for one cycle and its rdata=m_rdata. At all other times rdata=0.
- Responses return in issue order. Back-to-back reads sustain one response per cycle.
- busy = OR of the pipeline valid bits.
- Requester obligations: hold req/addr/wdata stable until the gnt cycle. A requester may drop req before gnt with no effect.
- The arbiter never back-pressures responses; requesters always accept rvalid.
- Write followed by a read to the same address is issued in order; the memory returns the new data.

Test Plan:
1. Reset and idle: hold rst=0 with f_req=1 -> all outputs 0. Release rst -> f_gnt=1 and m_en=1 in the same cycle; f_rvalid=1 exactly MEM_LAT cycles later with f_rdata equal to memory content.
2. Fetch stream: fetch word addresses 0x0,0x4,0x8 on consecutive cycles (MEM_LAT=1) with the memory preloaded with 0xFFC4A303, 0x00832383, 0x0062E233 -> f_rvalid=1 for 3 consecutive cycles with that data, in order.
3. Contention and starvation: f_req and l_req held high for 10 cycles (l_we=0, STARVE_MAX=4) -> grant pattern L,L,L,L,F,L,L,L,L,F; the rvalid owner sequence matches the grant sequence shifted by MEM_LAT.
4. Loader write then read-back: write 0x0064A423 to 0x10, then read 0x10 -> m_we=1 only in the write cycle; l_rvalid=1 with l_rdata=0x0064A423; f_rvalid stays 0.
5. Misaligned loader write to 0x13 -> l_err pulses once; m_addr=4, m_we=1.
6. Reset mid-flight: MEM_LAT=3, three fetch reads issued, rst=0 for one cycle -> no f_rvalid afterwards; busy=0 immediately on reset.
